// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and its surroundings.
// master drives buttons/tick/hit/miss; slave is the sequencer itself.
interface pong_game_ctrl_if;
  logic       refr_tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [1:0] balls_left;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic       timer_busy;

  modport master (
    output refr_tick, btn, hit, miss,
    input  gra_still, game_state, balls_left, score_d1, score_d0, timer_busy
  );

  modport slave (
    input  refr_tick, btn, hit, miss,
    output gra_still, game_state, balls_left, score_d1, score_d0, timer_busy
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball count, BCD score and pause timing over the frame tick.
// Optional macro PONG_AUTO_SERVE_EN serves a new ball without a button press.
module pong_game_ctrl #(
  parameter int unsigned BALLS       = 3,
  parameter int unsigned TIMER_TICKS = 120
) (
  input logic              clk,
  input logic              reset_n,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StNewGame = 2'b00,
    StPlay    = 2'b01,
    StNewBall = 2'b10,
    StOver    = 2'b11
  } state_e;

  localparam logic [1:0] BallsInit  = 2'(BALLS);
  localparam logic [1:0] BallsServe = 2'(BALLS - 1);
  localparam logic [6:0] TimerLoad  = 7'(TIMER_TICKS);

  state_e     state_q, state_d;
  logic [1:0] balls_q, balls_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic [6:0] timer_q, timer_d;
  logic       gra_still_q, gra_still_d;

  logic btn_press;
  logic timer_zero;

  assign btn_press  = (bus.btn != 2'b00);
  assign timer_zero = (timer_q == 7'd0);

  always_comb begin
    state_d = state_q;
    balls_d = balls_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    timer_d = timer_q;

    if (bus.refr_tick && !timer_zero) begin
      timer_d = timer_q - 7'd1;
    end

    unique case (state_q)
      StNewGame: begin
        d1_d    = 4'd0;
        d0_d    = 4'd0;
        balls_d = BallsInit;
        if (btn_press) begin
          state_d = StPlay;
          balls_d = BallsServe;
        end
      end
      StPlay: begin
        // miss takes priority over a coincident hit
        if (bus.miss) begin
          timer_d = TimerLoad;
          if (balls_q == 2'd0) begin
            state_d = StOver;
          end else begin
            state_d = StNewBall;
            balls_d = balls_q - 2'd1;
          end
        end else if (bus.hit) begin
          if (d0_q == 4'd9) begin
            d0_d = 4'd0;
            d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
          end else begin
            d0_d = d0_q + 4'd1;
          end
        end
      end
      StNewBall: begin
`ifdef PONG_AUTO_SERVE_EN
        if (timer_zero) begin
          state_d = StPlay;
        end
`else
        if (timer_zero && btn_press) begin
          state_d = StPlay;
        end
`endif
      end
      StOver: begin
        if (timer_zero) begin
          state_d = StNewGame;
          d1_d    = 4'd0;
          d0_d    = 4'd0;
          balls_d = BallsInit;
        end
      end
      default: state_d = StNewGame;
    endcase

    gra_still_d = (state_d != StPlay);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StNewGame;
      balls_q     <= BallsInit;
      d1_q        <= 4'd0;
      d0_q        <= 4'd0;
      timer_q     <= 7'd0;
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      balls_q     <= balls_d;
      d1_q        <= d1_d;
      d0_q        <= d0_d;
      timer_q     <= timer_d;
      gra_still_q <= gra_still_d;
    end
  end

  assign bus.gra_still  = gra_still_q;
  assign bus.game_state = state_q;
  assign bus.balls_left = balls_q;
  assign bus.score_d1   = d1_q;
  assign bus.score_d0   = d0_q;
  assign bus.timer_busy = !timer_zero;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (default parameters).
module tb_pong_game_ctrl;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .BALLS       (3),
    .TIMER_TICKS (120)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    step();
  endtask

  task automatic hit_pulse();
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
  endtask

  task automatic check_score(input string tag, input logic [7:0] exp);
    check(tag, {bus.score_d1, bus.score_d0}, exp);
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    reset_n       = 1'b0;
    bus.refr_tick = 1'b0;
    bus.btn       = 2'b00;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;
    #12;
    reset_n = 1'b1;
    repeat (10) step();

    check("rst_state", 8'(bus.game_state), 8'h00);
    check("rst_still", 8'(bus.gra_still), 8'h01);
    check("rst_balls", 8'(bus.balls_left), 8'h03);
    check_score("rst_score", 8'h00);
    check("rst_busy", 8'(bus.timer_busy), 8'h00);

    bus.btn = 2'b01;
    step();
    bus.btn = 2'b00;
    check("start_state", 8'(bus.game_state), 8'h01);
    check("start_still", 8'(bus.gra_still), 8'h00);
    check("start_balls", 8'(bus.balls_left), 8'h02);

    repeat (9) hit_pulse();
    check_score("score_09", 8'h09);
    hit_pulse();
    check_score("score_10_carry", 8'h10);
    repeat (2) hit_pulse();
    check_score("score_12", 8'h12);

    repeat (87) hit_pulse();
    check_score("score_99", 8'h99);
    hit_pulse();
    check_score("score_wrap_00", 8'h00);

    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    step();
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    check_score("hitmiss_score", 8'h00);
    check("hitmiss_state", 8'(bus.game_state), 8'h02);
    check("hitmiss_balls", 8'(bus.balls_left), 8'h01);
    check("hitmiss_busy", 8'(bus.timer_busy), 8'h01);
    check("hitmiss_still", 8'(bus.gra_still), 8'h01);

`ifdef PONG_AUTO_SERVE_EN
    bus.btn = 2'b00;
`else
    bus.btn = 2'b10;
`endif
    repeat (119) tick();
    check("nb_119_state", 8'(bus.game_state), 8'h02);
    check("nb_119_busy", 8'(bus.timer_busy), 8'h01);
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    check("nb_120_state", 8'(bus.game_state), 8'h02);
    check("nb_120_busy", 8'(bus.timer_busy), 8'h00);
    step();
    bus.btn = 2'b00;
    check("serve_state", 8'(bus.game_state), 8'h01);
    check("serve_still", 8'(bus.gra_still), 8'h00);

    // Second ball lost; this pause is served with no button held.
    bus.miss = 1'b1;
    step();
    bus.miss = 1'b0;
    check("nb2_state", 8'(bus.game_state), 8'h02);
    check("nb2_balls", 8'(bus.balls_left), 8'h00);
    repeat (119) tick();
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    check("nb2_busy", 8'(bus.timer_busy), 8'h00);
    step();
`ifdef PONG_AUTO_SERVE_EN
    check("nb2_auto_state", 8'(bus.game_state), 8'h01);
`else
    check("nb2_wait_state", 8'(bus.game_state), 8'h02);
    step();
    check("nb2_wait2_state", 8'(bus.game_state), 8'h02);
    bus.btn = 2'b01;
    step();
    bus.btn = 2'b00;
    check("nb2_btn_state", 8'(bus.game_state), 8'h01);
`endif

    repeat (2) hit_pulse();
    check_score("score_02", 8'h02);
    bus.miss = 1'b1;
    step();
    bus.miss = 1'b0;
    check("over_state", 8'(bus.game_state), 8'h03);
    check_score("over_score", 8'h02);
    check("over_busy", 8'(bus.timer_busy), 8'h01);
    bus.btn = 2'b11;
    step();
    bus.btn = 2'b00;
    check("over_btn_state", 8'(bus.game_state), 8'h03);
    repeat (119) tick();
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    check("over_120_state", 8'(bus.game_state), 8'h03);
    check_score("over_120_score", 8'h02);
    step();
    check("ng_state", 8'(bus.game_state), 8'h00);
    check_score("ng_score", 8'h00);
    check("ng_balls", 8'(bus.balls_left), 8'h03);
    check("ng_still", 8'(bus.gra_still), 8'h01);
    check("ng_busy", 8'(bus.timer_busy), 8'h00);

    bus.btn = 2'b01;
    step();
    bus.btn = 2'b00;
    hit_pulse();
    check("pre_rst_state", 8'(bus.game_state), 8'h01);
    check_score("pre_rst_score", 8'h01);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_state", 8'(bus.game_state), 8'h00);
    check("arst_still", 8'(bus.gra_still), 8'h01);
    check("arst_balls", 8'(bus.balls_left), 8'h03);
    check_score("arst_score", 8'h00);
    #2;
    reset_n = 1'b1;
    step();
    check("post_rst_state", 8'(bus.game_state), 8'h00);
    bus.btn = 2'b10;
    step();
    bus.btn = 2'b00;
    check("fresh_state", 8'(bus.game_state), 8'h01);
    check("fresh_balls", 8'(bus.balls_left), 8'h02);
    check_score("fresh_score", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
